// File: rtl/aes_pkg.sv
// Shared AES round-constant definitions.
// Holds key-length encodings, last-round numbers, the GF(2^8) reduction
// polynomial, the FSM state type and the byte stepping helpers.
package aes_pkg;

  localparam logic [1:0] KEY_LEN_128 = 2'd0;
  localparam logic [1:0] KEY_LEN_192 = 2'd1;
  localparam logic [1:0] KEY_LEN_256 = 2'd2;

  localparam logic [3:0] LAST_ROUND_128 = 4'd10;
  localparam logic [3:0] LAST_ROUND_192 = 4'd8;
  localparam logic [3:0] LAST_ROUND_256 = 4'd7;

  localparam logic [7:0] RCON_POLY  = 8'h1B;
  localparam logic [7:0] RCON_FIRST = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } rcon_state_t;

  // Multiply by x in GF(2^8): shift left, reduce when the old MSB was set.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  // Undo xtime: an odd byte can only come from a reduced product.
  function automatic logic [7:0] invXtime(input logic [7:0] b);
    if (b[0]) begin
      return ((b ^ RCON_POLY) >> 1) | 8'h80;
    end
    return b >> 1;
  endfunction

  // Encoding 3 is not a real key length and falls back to AES-128.
  function automatic logic [3:0] lastRound(input logic [1:0] keyLen);
    case (keyLen)
      KEY_LEN_192: return LAST_ROUND_192;
      KEY_LEN_256: return LAST_ROUND_256;
      default:     return LAST_ROUND_128;
    endcase
  endfunction

  // Constant of the final round, the starting point of a reverse walk.
  function automatic logic [7:0] lastRcon(input logic [1:0] keyLen);
    case (keyLen)
      KEY_LEN_192: return 8'h80;
      KEY_LEN_256: return 8'h40;
      default:     return 8'h36;
    endcase
  endfunction

endpackage

// File: rtl/rcon_gen_if.sv
// Control/result bundle between a key-schedule client and rcon_gen.
// The client (master) issues start/next pulses; the generator (slave)
// returns the current round constant with its round number and status.
interface rcon_gen_if #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 4
);

  logic              start;
  logic              next;
  logic [1:0]        key_len;
  logic              dir;
  logic [WORD_W-1:0] rcon_word;
  logic [IDX_W-1:0]  round_idx;
  logic              valid;
  logic              done;

  modport master (
    output start, next, key_len, dir,
    input  rcon_word, round_idx, valid, done
  );

  modport slave (
    input  start, next, key_len, dir,
    output rcon_word, round_idx, valid, done
  );

endinterface

// File: rtl/rcon_step.sv
// Combinational single-step round-constant stepper.
// Forward multiplies by x; with RCON_REVERSE_EN defined, i_dir=1 divides
// by x instead. Without the macro only the forward path exists and the top
// always drives i_dir low.
import aes_pkg::*;

module rcon_step (
  input  logic [7:0] i_byte,
  input  logic       i_dir,
  output logic [7:0] o_byte
);

`ifdef RCON_REVERSE_EN
  // Choose multiply or divide by x depending on the walk direction.
  always_comb begin
    o_byte = xtime(i_byte);
    if (i_dir) begin
      o_byte = invXtime(i_byte);
    end
  end
`else
  // Forward-only stepping; a reverse request has no meaning in this build.
  always_comb begin
    o_byte = xtime(i_byte) & {8{~i_dir}};
  end
`endif

endmodule

// File: rtl/rcon_gen.sv
// AES key-expansion round-constant generator.
// Walks the Rcon sequence one step per accepted next pulse, for AES-128/192/256.
// Optional macro RCON_REVERSE_EN adds reverse walking (last round down to 1).
import aes_pkg::*;

module rcon_gen #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic        clk,
  input  logic        rst,
  rcon_gen_if.slave   bus
);

  rcon_state_t      r_state;
  logic [7:0]       r_byte;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_keyLen;
  logic             r_dir;

  rcon_state_t      w_state;
  logic [7:0]       w_byte;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_keyLen;
  logic             w_dir;
  logic             w_dirReq;
  logic [7:0]       w_stepByte;
  logic [IDX_W-1:0] w_lastIdx;
  logic [IDX_W-1:0] w_endIdx;

`ifdef RCON_REVERSE_EN
  assign w_dirReq = bus.dir;
`else
  assign w_dirReq = bus.dir & 1'b0;
`endif

  assign w_lastIdx = IDX_W'(lastRound(r_keyLen));
  assign w_endIdx  = r_dir ? IDX_W'(1) : w_lastIdx;

  rcon_step u_step (
    .i_byte (r_byte),
    .i_dir  (r_dir),
    .o_byte (w_stepByte)
  );

  // Next-state logic: start restarts from any state and beats next;
  // next only moves the schedule while running.
  always_comb begin
    w_state  = r_state;
    w_byte   = r_byte;
    w_idx    = r_idx;
    w_keyLen = r_keyLen;
    w_dir    = r_dir;
    if (bus.start) begin
      w_state  = RUN;
      w_keyLen = bus.key_len;
      w_dir    = w_dirReq;
      if (w_dirReq) begin
        w_idx  = IDX_W'(lastRound(bus.key_len));
        w_byte = lastRcon(bus.key_len);
      end else begin
        w_idx  = IDX_W'(1);
        w_byte = RCON_FIRST;
      end
    end else if (bus.next && (r_state == RUN)) begin
      if (r_idx == w_endIdx) begin
        w_state = DONE;
      end else begin
        w_byte = w_stepByte;
        w_idx  = r_dir ? (r_idx - IDX_W'(1)) : (r_idx + IDX_W'(1));
      end
    end
  end

  // State register with synchronous reset that clears every visible value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_byte   <= 8'h00;
      r_idx    <= '0;
      r_keyLen <= 2'd0;
      r_dir    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_byte   <= w_byte;
      r_idx    <= w_idx;
      r_keyLen <= w_keyLen;
      r_dir    <= w_dir;
    end
  end

  assign bus.rcon_word = WORD_W'(r_byte) << (WORD_W - 8);
  assign bus.round_idx = r_idx;
  assign bus.valid     = (r_state == RUN);
  assign bus.done      = (r_state == DONE);

endmodule

// File: tb/tb_rcon_gen.sv
// Scoreboard testbench for rcon_gen.
// The driver pushes one expected output record per clock it drives; a
// separate monitor pops and compares after every rising edge.
`timescale 1ns/1ps

module tb_rcon_gen;

  localparam int WORD_W = 32;
  localparam int IDX_W  = 4;

  typedef struct {
    logic [WORD_W-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic              valid;
    logic              done;
    string             tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int compareCount  = 0;
  int mismatchCount = 0;

  exp_t expQ[$];

  logic [7:0] fwdTab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  rcon_gen_if #(.WORD_W(WORD_W), .IDX_W(IDX_W)) bus ();

  rcon_gen #(.WORD_W(WORD_W), .IDX_W(IDX_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input exp_t e);
    compareCount++;
    if (bus.rcon_word !== e.word || bus.round_idx !== e.idx ||
        bus.valid !== e.valid || bus.done !== e.done) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got word=%h idx=%0d valid=%b done=%b, required word=%h idx=%0d valid=%b done=%b",
               e.tag, bus.rcon_word, bus.round_idx, bus.valid, bus.done,
               e.word, e.idx, e.valid, e.done);
    end
  endtask

  // Monitor: after each rising edge, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic applyStimulus(input logic iRst, input logic iStart, input logic iNext,
                               input logic [1:0] kl, input logic d,
                               input logic [7:0] eByte, input int eIdx,
                               input logic eValid, input logic eDone, input string tag);
    exp_t e;
    @(negedge clk);
    rst         = iRst;
    bus.start   = iStart;
    bus.next    = iNext;
    bus.key_len = kl;
    bus.dir     = d;
    e.word  = {eByte, 24'h000000};
    e.idx   = IDX_W'(eIdx);
    e.valid = eValid;
    e.done  = eDone;
    e.tag   = tag;
    expQ.push_back(e);
    @(posedge clk);
  endtask

  // Full forward schedule: start, walk to the last round, finish, then one ignored next.
  task automatic runForward(input logic [1:0] kl, input int lastR, input string name);
    applyStimulus(0, 1, 0, kl, 0, 8'h01, 1, 1, 0, {name, "_start"});
    for (int r = 2; r <= lastR; r++) begin
      applyStimulus(0, 0, 1, kl, 0, fwdTab[r-1], r, 1, 0, $sformatf("%s_r%0d", name, r));
    end
    applyStimulus(0, 0, 1, kl, 0, fwdTab[lastR-1], lastR, 0, 1, {name, "_done"});
    applyStimulus(0, 0, 1, kl, 0, fwdTab[lastR-1], lastR, 0, 1, {name, "_next_in_done"});
    applyStimulus(0, 0, 0, kl, 0, fwdTab[lastR-1], lastR, 0, 1, {name, "_done_hold"});
  endtask

`ifdef RCON_REVERSE_EN
  task automatic runReverse(input logic [1:0] kl, input int lastR, input string name);
    applyStimulus(0, 1, 0, kl, 1, fwdTab[lastR-1], lastR, 1, 0, {name, "_start"});
    for (int r = lastR - 1; r >= 1; r--) begin
      applyStimulus(0, 0, 1, kl, 0, fwdTab[r-1], r, 1, 0, $sformatf("%s_r%0d", name, r));
    end
    applyStimulus(0, 0, 1, kl, 0, 8'h01, 1, 0, 1, {name, "_done"});
  endtask
`endif

  initial begin
    int waitCycles;
    bus.start   = 1'b0;
    bus.next    = 1'b0;
    bus.key_len = 2'd0;
    bus.dir     = 1'b0;

    applyStimulus(1, 0, 0, 2'd0, 0, 8'h00, 0, 0, 0, "reset");
    applyStimulus(1, 1, 1, 2'd0, 0, 8'h00, 0, 0, 0, "reset_overrides_start");
    applyStimulus(0, 0, 1, 2'd0, 0, 8'h00, 0, 0, 0, "next_in_idle");

    runForward(2'd0, 10, "aes128");
    runForward(2'd2, 7,  "aes256");
    runForward(2'd1, 8,  "aes192");
    runForward(2'd3, 10, "keylen3");

    // Restart mid-run: start and next together at round 5.
    applyStimulus(0, 1, 0, 2'd0, 0, 8'h01, 1, 1, 0, "restart_start");
    for (int r = 2; r <= 5; r++) begin
      applyStimulus(0, 0, 1, 2'd0, 0, fwdTab[r-1], r, 1, 0, $sformatf("restart_r%0d", r));
    end
    applyStimulus(0, 1, 1, 2'd0, 0, 8'h01, 1, 1, 0, "start_beats_next");
    applyStimulus(0, 0, 1, 2'd0, 0, 8'h02, 2, 1, 0, "after_restart_r2");

    // Reset at round 4 while next is high.
    applyStimulus(0, 1, 0, 2'd1, 0, 8'h01, 1, 1, 0, "abort_start");
    for (int r = 2; r <= 4; r++) begin
      applyStimulus(0, 0, 1, 2'd1, 0, fwdTab[r-1], r, 1, 0, $sformatf("abort_r%0d", r));
    end
    applyStimulus(1, 0, 1, 2'd1, 0, 8'h00, 0, 0, 0, "reset_mid_run");
    applyStimulus(0, 0, 1, 2'd1, 0, 8'h00, 0, 0, 0, "next_after_reset");
    applyStimulus(0, 1, 0, 2'd0, 0, 8'h01, 1, 1, 0, "fresh_start_after_reset");

`ifdef RCON_REVERSE_EN
    runReverse(2'd0, 10, "rev128");
    runReverse(2'd1, 8,  "rev192");
    runReverse(2'd2, 7,  "rev256");
    applyStimulus(0, 1, 0, 2'd0, 0, 8'h01, 1, 1, 0, "forward_after_reverse");
`else
    applyStimulus(0, 1, 0, 2'd0, 1, 8'h01, 1, 1, 0, "dir_ignored_start");
    applyStimulus(0, 0, 1, 2'd0, 1, 8'h02, 2, 1, 0, "dir_ignored_r2");
`endif

    @(negedge clk);
    bus.start = 1'b0;
    bus.next  = 1'b0;

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    if (expQ.size() > 0) begin
      compareCount++;
      mismatchCount++;
      $display("[TB] FAIL drain: got %0d pending expectations, required 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/rcon_gen.md
RCON_GEN -- requirements
Module: rcon_gen

Interface
REQ-001 Parameter WORD_W, default 32: width of rcon_word; SHALL be >= 8; constant byte occupies bits [WORD_W-1:WORD_W-8], all other bits zero.
REQ-002 Parameter IDX_W, default 4: width of round_idx.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; loads first constant of a new schedule.
REQ-006 next  input  1  one-cycle pulse; advances to following constant.
REQ-007 key_len  input  2  0=AES-128, 1=AES-192, 2=AES-256, 3=treated as AES-128; sampled only on accepted start.
REQ-008 dir  input  1  0=forward, 1=reverse; sampled only on accepted start; ignored unless RCON_REVERSE_EN.
REQ-009 rcon_word  output  WORD_W  current round constant word.
REQ-010 round_idx  output  IDX_W  current round number, 1-based.
REQ-011 valid  output  1  rcon_word/round_idx hold a schedule constant.
REQ-012 done  output  1  final constant of schedule has been consumed.

Function
REQ-013 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 Last round L SHALL be 10 (AES-128), 8 (AES-192), 7 (AES-256), latched at start.
REQ-015 start in any state SHALL move to RUN next cycle with valid=1, done=0, round_idx=1, byte=0x01 (forward).
REQ-016 Latency: start at edge N -> constant visible after edge N (one cycle); no combinational path from inputs to outputs.
REQ-017 next in RUN with round_idx<L: byte <= xtime(byte) (shift left 1; XOR 0x1B if old bit7=1), round_idx <= round_idx+1.
REQ-018 next in RUN with round_idx=L: state DONE, valid=0, done=1, rcon_word and round_idx hold last values.
REQ-019 next in IDLE or DONE SHALL be ignored.
REQ-020 start and next in same cycle: start wins; next discarded.
REQ-021 Back-to-back next every cycle SHALL advance one step per cycle without loss.
REQ-022 Forward sequence: 01,02,04,08,10,20,40,80,1B,36 truncated at L.
REQ-023 done SHALL stay 1 in DONE until next start or rst.

Reset
REQ-024 rst SHALL override start/next; after rst: state IDLE, rcon_word=0, round_idx=0, valid=0, done=0, latched key_len=0, latched dir=0.
REQ-025 rst asserted mid-RUN SHALL abort schedule; following start begins fresh from REQ-015.

Configuration
REQ-026 Macro RCON_REVERSE_EN: when defined, dir=1 at start loads round_idx=L with byte = constant of round L (0x36/0x80/0x40 for 128/192/256); each next applies inverse xtime (if bit0=1: (byte XOR 0x1B)>>1 OR 0x80, else byte>>1) and decrements round_idx; next at round_idx=1 enters DONE.
REQ-027 Without RCON_REVERSE_EN: dir port present but ignored; behaviour forward only; no inverse logic synthesised.

Structure
REQ-028 Shared package aes_pkg SHALL hold key-length encodings, last-round constants (10/8/7), RCON_POLY=0x1B, and the xtime/inverse-xtime functions.
REQ-029 One sub-module rcon_step: combinational byte stepper (input byte, dir; output next byte), instantiated once.

Verification
REQ-030 AES-128 forward: start, then 10 nexts -> bytes 01,02,04,08,10,20,40,80,1B,36 with round_idx 1..10; 10th next -> done=1, valid=0.
REQ-031 AES-256 forward, next held high 8 cycles -> rounds 1..7 ending 0x40, done=1 after 7th next, 8th next ignored.
REQ-032 start+next same cycle in RUN at round 5 -> round_idx=1, byte 0x01.
REQ-033 rst asserted at round 4 with next high -> all outputs zero next cycle, state IDLE; later next ignored.
REQ-034 RCON_REVERSE_EN, AES-128, dir=1 -> 36,1B,80,40,20,10,08,04,02,01 with round_idx 10..1; next after round 1 -> done=1.
REQ-035 key_len=3 -> identical to AES-128 sequence, done after round 10.
